// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, runs a req/ack handshake to instruction
// memory and queues {pc, inst} pairs for decode. Optional FETCH_PERF_EN adds a bubble counter.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_bubble_o
`endif
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    localparam cnt_t        FULL = cnt_t'(QDEPTH);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        KILL = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] kill_addr_q, kill_addr_d;
    cnt_t        count_q, count_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    logic [31:0] q_pc_q   [QDEPTH];
    logic [31:0] q_pc_d   [QDEPTH];
    logic [31:0] q_inst_q [QDEPTH];
    logic [31:0] q_inst_d [QDEPTH];

    logic push;
    logic pop;

    // Handshake and queue-head outputs; everything is forced idle while rst is high.
    always_comb begin
        inst_valid_o = ~rst & (count_q != '0);
        pop          = inst_valid_o & ~stall_i;
        mem_req_o    = ~rst & ((state_q == KILL) | (count_q < FULL) | pop);
        mem_addr_o   = (state_q == KILL) ? kill_addr_q : fetch_pc_q;
        push         = (state_q == RUN) & mem_req_o & mem_ack_i & ~branch_flag_i;
        pc_o         = inst_valid_o ? q_pc_q[rd_ptr_q] : 32'h0;
        inst_o       = inst_valid_o ? q_inst_q[rd_ptr_q] : NOP;
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        kill_addr_d = kill_addr_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        q_pc_d      = q_pc_q;
        q_inst_d    = q_inst_q;

        if (branch_flag_i) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = branch_target_i & 32'hFFFF_FFFC;
            // An unacked request cannot be withdrawn, so its data must be swallowed later.
            if ((state_q == RUN) && mem_req_o && !mem_ack_i) begin
                kill_addr_d = fetch_pc_q;
                state_d     = KILL;
            end else if ((state_q == KILL) && mem_ack_i) begin
                state_d = RUN;
            end
        end else begin
            if ((state_q == KILL) && mem_ack_i) begin
                state_d = RUN;
            end
            if (push) begin
                q_pc_d[wr_ptr_q]   = fetch_pc_q;
                q_inst_d[wr_ptr_q] = mem_rdata_i;
                wr_ptr_d           = wr_ptr_q + ptr_t'(1);
                fetch_pc_d         = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = inst_valid_o ? perf_q : perf_q + 32'd1;
    end

    assign perf_bubble_o = perf_q;
`endif

    always_ff @(posedge clk) begin
        q_pc_q   <= q_pc_d;
        q_inst_q <= q_inst_d;
        if (rst) begin
            state_q     <= RUN;
            fetch_pc_q  <= RESET_PC;
            kill_addr_q <= 32'h0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
`ifdef FETCH_PERF_EN
            perf_q      <= 32'h0;
`endif
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            kill_addr_q <= kill_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
`ifdef FETCH_PERF_EN
            perf_q      <= perf_d;
`endif
        end
    end

endmodule
